// File: rtl/serial_pkg.sv
// Shared definitions for the serial sync-word detector and the frame capture block.
// Holds the capture FSM encoding, the sync word and the default payload width.
package serial_pkg;

    typedef enum logic {
        HUNT    = 1'b0,
        CAPTURE = 1'b1
    } state_t;

    localparam logic [6:0] SYNC_WORD      = 7'b1001001;
    localparam int         DEFAULT_DATA_W = 8;

endpackage

// File: rtl/serial_frame_capture.sv
// Captures DATA_W payload bits after a detector match and hands them out on valid/ready.
// Word appears DATA_W cycles after match; a frame completing into an occupied slot is dropped and flagged.
module serial_frame_capture
    import serial_pkg::*;
#(
    parameter int DATA_W    = DEFAULT_DATA_W,
    parameter int MSB_FIRST = 1,
    parameter int CNT_W     = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              serial_line,
    input  logic              match,
    input  logic              data_ready,
    input  logic              overrun_clr,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              overrun,
    output logic [CNT_W-1:0]  frame_count
);

    localparam int BW = $clog2(DATA_W + 1);

    state_t            state;
    state_t            state_nxt;
    logic [BW-1:0]     bit_cnt;
    logic [DATA_W-1:0] shift_reg;
    logic [DATA_W-1:0] shift_nxt;
    logic              sampling;
    logic              complete;
    logic              slot_free;

    // shift_nxt already holds the current bit, so it is the finished word in the completion cycle
    always_comb begin
        shift_nxt = (MSB_FIRST != 0) ? {shift_reg[DATA_W-2:0], serial_line}
                                     : {serial_line, shift_reg[DATA_W-1:1]};
        sampling  = (state == CAPTURE) || match;
        complete  = (state == CAPTURE) && (bit_cnt == BW'(DATA_W - 1));
        slot_free = !data_valid || data_ready;
        state_nxt = state;
        case (state)
            HUNT:    if (match)    state_nxt = CAPTURE;
            CAPTURE: if (complete) state_nxt = HUNT;
            default:               state_nxt = HUNT;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= HUNT;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bit_cnt   <= '0;
            shift_reg <= '0;
        end else begin
            if (sampling) begin
                shift_reg <= shift_nxt;
            end
            if (complete) begin
                bit_cnt <= '0;
            end else if (sampling) begin
                bit_cnt <= bit_cnt + BW'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            data_out    <= '0;
            data_valid  <= 1'b0;
            overrun     <= 1'b0;
            frame_count <= '0;
        end else begin
            if (complete && slot_free) begin
                data_out    <= shift_nxt;
                data_valid  <= 1'b1;
                frame_count <= frame_count + CNT_W'(1);
            end else if (data_valid && data_ready) begin
                data_valid <= 1'b0;
            end
            // a drop in the same cycle as a clear leaves the flag set
            if (complete && !slot_free) begin
                overrun <= 1'b1;
            end else if (overrun_clr) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: doc/serial_frame_capture.md
Name: serial_frame_capture

Overview:
Downstream companion of the serial-line pattern detector (sync word 1001001). It consumes that detector's registered `match` pulse plus the same `serial_line`, captures the DATA_W payload bits that follow the sync word, and presents them as a parallel word on a valid/ready output. It also keeps a delivered-frame counter and a sticky overrun flag for software/debug.

Parameters:
- DATA_W, default 8: payload bits per frame; legal range 2..32.
- MSB_FIRST, default 1: 1 = first payload bit lands in data_out[DATA_W-1]; 0 = first bit lands in data_out[0].
- CNT_W, default 16: width of frame_count.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- serial_line  input  1  serial bit stream, same signal that feeds the detector.
- match  input  1  detector output; high for one cycle immediately after the last sync bit was sampled.
- data_ready  input  1  consumer accepts data_out this cycle when data_valid=1.
- overrun_clr  input  1  synchronous clear of the overrun flag.
- data_out  output  DATA_W  captured payload; held stable while data_valid=1.
- data_valid  output  1  payload word available.
- overrun  output  1  sticky; a completed frame was dropped because the output was still occupied.
- frame_count  output  CNT_W  number of frames delivered to data_out; wraps modulo 2^CNT_W.

Behaviour:
- Reset (asynchronous, reset=0) forces:
  - state HUNT, bit_cnt=0, shift register 0;
  - data_out=0, data_valid=0, overrun=0, frame_count=0.
- States:
  - HUNT, CAPTURE. Encoding is 1 bit; values come from the shared package.
- HUNT:
  - In a cycle with match=1, serial_line in that same cycle is payload bit 0.
  - Shift it in, set bit_cnt=1, go to CAPTURE.
  - match=0: stay in HUNT.
- CAPTURE:
  - Every cycle, shift in serial_line and increment bit_cnt.
  - match is ignored in this state; overlapping sync words inside the payload do not restart capture.
  - The cycle in which bit DATA_W-1 is sampled is the completion cycle.
  - At the end of the completion cycle: return to HUNT and clear bit_cnt.
- Latency:
  - match high in cycle T → bits sampled in cycles T..T+DATA_W-1.
  - data_valid rises in cycle T+DATA_W.
  - A new match is accepted from cycle T+DATA_W onwards.
- Completion and delivery:
  - Slot free means data_valid=0, or data_valid=1 and data_ready=1, in the completion cycle.
  - Slot free: load data_out with the assembled word, set data_valid=1, frame_count+1.
  - Simultaneous accept and completion: data_valid stays 1 and data_out takes the new word with no bubble.
  - Slot occupied (data_valid=1, data_ready=0): drop the new word, set overrun=1. data_out, data_valid and frame_count are unchanged.
- Output handshake:
  - data_valid falls on the edge after a cycle with data_valid=1 and data_ready=1, unless a new word loads on that edge.
  - data_ready while data_valid=0 has no effect.
- Overrun:
  - overrun_clr=1 clears the flag.
  - If set and clear occur in the same cycle, set wins.
- frame_count:
  - Wraps from 2^CNT_W-1 to 0 with no flag.
  - Dropped frames are not counted.
- Bit ordering: MSB_FIRST=0 places the first sampled bit at bit 0; the assembled word is fully determined at completion.
- Reset mid-CAPTURE: the partial frame is discarded and state returns to HUNT. After reset release, there is no output until a fresh match.

Decomposition:
- Shared package serial_pkg holds:
  - state localparams (HUNT=1'b0, CAPTURE=1'b1);
  - the sync-word constant 7'b1001001;
  - the default DATA_W, for reuse by the detector and this block.
- No sub-module. The bit counter, shift register and output slot are small enough to sit inline in a single module.

Test Plan:
1. DATA_W=8, MSB_FIRST=1; drive 1001001 then 00011111, data_ready=1 → data_valid high for one cycle 8 cycles after match; data_out=0x1F; frame_count=1; overrun=0.
2. MSB_FIRST=0, same stream → data_out=0xF8.
3. Payload 0x92 (10010010, contains 1001001 via overlap) → exactly one frame 0x92; a detector match pulse during capture causes no restart; frame_count=1.
4. data_ready=0, two back-to-back frames 0xA5 then 0x3C → data_out holds 0xA5, overrun=1, frame_count=1. Then overrun_clr=1 → overrun=0. Then data_ready=1 → data_valid falls.
5. Word 0x11 pending; second frame 0x22 completes in the same cycle data_ready=1 → data_valid stays 1; data_out=0x22 on the next cycle; frame_count=2; no overrun.
6. Reset asserted at bit 4 of capture, released, then full frame 0x5A → only 0x5A delivered; frame_count=1. CNT_W=2 with 5 frames → frame_count wraps to 1.
